sipo_deser: RTL and testbench

Serial-in, parallel-out deserializer that sits directly upstream of the team's 4-bit `pipo` register stage. It collects a qualified serial bit stream into WIDTH-bit words and presents each completed word on a registered parallel output with a valid/ready handshake. A one-word holding register decouples shifting from downstream capture. A sticky flag reports words dropped under backpressure.

---
 rtl/sipo_deser.sv | 57 +++++
 tb/tb_sipo_deser.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer with a one-word holding register,
// a valid/ready handshake and a sticky overrun flag for words dropped under backpressure.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             clear_ovr,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_ovr;
    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_free;
    // The load candidate already includes the bit sampled on this edge.
    assign w_word = MSB_FIRST ? {r_sr[WIDTH-2:0], sin} : {sin, r_sr[WIDTH-1:1]};
    assign w_done = sin_valid && (r_cnt == CW'(WIDTH - 1));
    assign w_free = !r_valid || dout_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (sin_valid) begin
                r_sr  <= w_word;
                r_cnt <= w_done ? '0 : r_cnt + CW'(1);
            end
            if (w_done && w_free) begin
                r_dout  <= w_word;
                r_valid <= 1'b1;
            end else if (r_valid && dout_ready) begin
                r_valid <= 1'b0;
            end
            if (w_done && !w_free) r_ovr <= 1'b1;
            else if (clear_ovr) r_ovr <= 1'b0;
        end
    end
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign overrun    = r_ovr;
    assign busy       = (r_cnt != '0);
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: scoreboard bench driving an MSB-first and an LSB-first instance in parallel.
module tb_sipo_deser;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       dout_ready = 1'b0;
    logic       clear_ovr = 1'b0;
    logic [3:0] dm, dl;
    logic       vm, vl, om, ol, bm, bl;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] q_m[$];
    logic [3:0] q_l[$];
    logic       bits[$];
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .dout(dm), .dout_valid(vm), .dout_ready(dout_ready),
        .overrun(om), .clear_ovr(clear_ovr), .busy(bm)
    );
    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .dout(dl), .dout_valid(vl), .dout_ready(dout_ready),
        .overrun(ol), .clear_ovr(clear_ovr), .busy(bl)
    );

    // Drive one cycle of inputs; the model pushes completed words and pops consumed ones.
    task automatic step(input logic v, input logic s, input logic r, input logic c);
        logic       done, free;
        logic [3:0] wm, wl;
        sin_valid = v; sin = s; dout_ready = r; clear_ovr = c;
        @(posedge clk);
        done = v && (bits.size() == 3);
        free = !m_valid || r;
        wm = 4'b0; wl = 4'b0;
        if (m_valid && r && q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        if (v) bits.push_back(s);
        if (done) begin
            wm = {bits[0], bits[1], bits[2], bits[3]};
            wl = {bits[3], bits[2], bits[1], bits[0]};
            bits.delete();
        end
        if (done && free) begin
            q_m.push_back(wm);
            q_l.push_back(wl);
            m_valid = 1'b1;
        end else if (m_valid && r) m_valid = 1'b0;
        if (done && !free) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        #1;
    endtask

    task automatic model_reset();
        bits.delete(); q_m.delete(); q_l.delete();
        m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    function automatic logic [3:0] front_m();
        return (q_m.size() > 0) ? q_m[0] : 4'bxxxx;
    endfunction

    function automatic logic [3:0] front_l();
        return (q_l.size() > 0) ? q_l[0] : 4'bxxxx;
    endfunction

    task automatic test_reset();
        #3;
        n_tests++;
        if ({dm, vm, om, bm, dl, vl, ol, bl} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=0", {dm, vm, om, bm, dl, vl, ol, bl});
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        logic [3:0] w;
        w = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, w[i], 1'b1, 1'b0);
            if (i == 3) begin
                n_tests++;
                if (bm !== 1'b1) begin n_fail++; $display("FAIL msb_busy_bit1 got=%b want=1", bm); end
            end
        end
        n_tests++;
        if (dm !== 4'b1011 || dm !== front_m()) begin
            n_fail++; $display("FAIL msb_word got=%b want=1011 sb=%b", dm, front_m());
        end
        n_tests++;
        if (vm !== 1'b1 || bm !== 1'b0) begin
            n_fail++; $display("FAIL msb_valid_busy got=%b%b want=10", vm, bm);
        end
        n_tests++;
        if (dl !== 4'b1101 || dl !== front_l()) begin
            n_fail++; $display("FAIL msb_lsbinst_word got=%b want=1101", dl);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (vm !== 1'b0 || dm !== 4'b1011) begin
            n_fail++; $display("FAIL msb_one_cycle got=v%b d%b want=v0 d1011", vm, dm);
        end
    endtask

    task automatic test_lsb_gaps();
        logic [3:0] w;
        int         bad;
        w = 4'b1101;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, w[i], 1'b1, 1'b0);
            if (i < 3) for (int g = 0; g < 3; g++) begin
                step(1'b0, 1'b1, 1'b1, 1'b0);
                if (bl !== 1'b1 || vl !== 1'b0) bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL lsb_gap_busy bad_cycles=%0d want=0", bad); end
        n_tests++;
        if (dl !== 4'b1101 || dl !== front_l() || vl !== 1'b1) begin
            n_fail++; $display("FAIL lsb_word got=v%b d%b want=v1 d1101", vl, dl);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [3:0] w;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({dm, vm, om, bm, dl, vl, ol, bl} !== 12'b0) begin
            n_fail++; $display("FAIL midword_reset got=%b want=0", {dm, vm, om, bm, dl, vl, ol, bl});
        end
        rst = 1'b0;
        model_reset();
        w = 4'b0110;
        for (int i = 3; i >= 0; i--) step(1'b1, w[i], 1'b1, 1'b0);
        n_tests++;
        if (dm !== 4'b0110 || dm !== front_m() || vm !== 1'b1) begin
            n_fail++; $display("FAIL after_reset_word got=v%b d%b want=v1 d0110", vm, dm);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        logic [7:0] w;
        w = 8'b1011_0110;
        for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0);
        n_tests++;
        if (dm !== 4'b1011 || dm !== front_m() || vm !== 1'b1 || om !== 1'b1) begin
            n_fail++; $display("FAIL overrun_set got=d%b v%b o%b want=d1011 v1 o1", dm, vm, om);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (vm !== 1'b0 || om !== 1'b1) begin
            n_fail++; $display("FAIL overrun_consume got=v%b o%b want=v0 o1", vm, om);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (om !== 1'b0 || ol !== 1'b0) begin
            n_fail++; $display("FAIL overrun_clear got=%b%b want=00", om, ol);
        end
    endtask

    task automatic test_simul_consume();
        logic [7:0] w;
        w = 8'b1011_0110;
        for (int i = 7; i >= 0; i--) step(1'b1, w[i], i == 0, 1'b0);
        n_tests++;
        if (dm !== 4'b0110 || dm !== front_m() || vm !== 1'b1 || om !== 1'b0) begin
            n_fail++; $display("FAIL simul_consume got=d%b v%b o%b want=d0110 v1 o0", dm, vm, om);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_priority_stream();
        logic [3:0] w;
        int         pulses, bad;
        for (int i = 0; i < 8; i++) step(1'b1, i[0], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, i == 3);
        n_tests++;
        if (om !== 1'b1 || om !== m_ovr) begin
            n_fail++; $display("FAIL set_beats_clear got=%b want=1", om);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (om !== 1'b0 || vm !== 1'b0) begin
            n_fail++; $display("FAIL pre_stream_clear got=o%b v%b want=o0 v0", om, vm);
        end
        pulses = 0;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            w = 4'($urandom_range(0, 15));
            for (int i = 3; i >= 0; i--) begin
                step(1'b1, w[i], 1'b1, 1'b0);
                if (vm === 1'b1) begin
                    pulses++;
                    if (i != 0 || dm !== w || dm !== front_m() || dl !== front_l()) bad++;
                end else if (i == 0) bad++;
            end
        end
        n_tests++;
        if (pulses != 8 || bad != 0) begin
            n_fail++; $display("FAIL stream got pulses=%0d bad=%0d want pulses=8 bad=0", pulses, bad);
        end
        n_tests++;
        if (om !== 1'b0 || ol !== 1'b0) begin
            n_fail++; $display("FAIL stream_overrun got=%b%b want=00", om, ol);
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gaps();
        test_reset_mid();
        test_overrun();
        test_simul_consume();
        test_priority_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
